// File: rtl/bus_mux_arbiter.sv
// rtl/bus_mux_arbiter.sv - two-into-one valid/ready stream merger with round-robin grant
// Each output word is tagged with sel (1 = i1, 0 = i2) so a downstream demux can split it back.
module bus_mux_arbiter #(
  parameter int w  = 8,
  parameter int cw = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [w-1:0]  i1,
  input  logic          i1_valid,
  output logic          i1_ready,
  input  logic [w-1:0]  i2,
  input  logic          i2_valid,
  output logic          i2_ready,
  output logic [w-1:0]  o,
  output logic          sel,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [cw-1:0] cnt1,
  output logic [cw-1:0] cnt2
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state, state_nxt;
  logic   last;
  logic   accept;
  logic   g1;
  logic   g2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Grants are masked by rst so nothing handshakes while reset is held.
  always_comb begin
    accept    = (state == EMPTY) | o_ready;
    g1        = !rst & accept & i1_valid & (!i2_valid | !last);
    g2        = !rst & accept & i2_valid & !g1;
    state_nxt = state;
    case (state)
      EMPTY:   if (g1 | g2)            state_nxt = FULL;
      FULL:    if (o_ready & !(g1 | g2)) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    o_valid  = (state == FULL);
    i1_ready = g1;
    i2_ready = g2;
  end

  // last points at the channel served most recently; the other one wins contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o    <= '0;
      sel  <= 1'b0;
      last <= 1'b0;
      cnt1 <= '0;
      cnt2 <= '0;
    end else if (g1) begin
      o    <= i1;
      sel  <= 1'b1;
      last <= 1'b1;
      cnt1 <= cnt1 + {{(cw-1){1'b0}}, 1'b1};
    end else if (g2) begin
      o    <= i2;
      sel  <= 1'b0;
      last <= 1'b0;
      cnt2 <= cnt2 + {{(cw-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_bus_mux_arbiter.sv
// tb/tb_bus_mux_arbiter.sv - self-checking bench for bus_mux_arbiter
module tb_bus_mux_arbiter;
  localparam int W  = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  i1, i2, o;
  logic          i1_valid, i2_valid, i1_ready, i2_ready;
  logic          sel, o_valid, o_ready;
  logic [CW-1:0] cnt1, cnt2;

  int compared   = 0;
  int mismatched = 0;

  // reference model: one slot, who was served last, per-channel totals
  bit       m_full;
  bit       m_tag;
  bit [7:0] m_data;
  int       m_last_src;
  int       m_tot1, m_tot2;

  bus_mux_arbiter #(.w(W), .cw(CW)) dut (
    .clk(clk), .rst(rst),
    .i1(i1), .i1_valid(i1_valid), .i1_ready(i1_ready),
    .i2(i2), .i2_valid(i2_valid), .i2_ready(i2_ready),
    .o(o), .sel(sel), .o_valid(o_valid), .o_ready(o_ready),
    .cnt1(cnt1), .cnt2(cnt2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_full = 0; m_tag = 0; m_data = 0; m_last_src = 2; m_tot1 = 0; m_tot2 = 0;
  endtask

  // Inputs are already driven; check handshakes, clock once, check registered outputs.
  task automatic step();
    bit       can_take;
    int       winner;
    bit [7:0] d1, d2;
    #1;
    can_take = !m_full || o_ready;
    winner   = 0;
    if (can_take) begin
      if (i1_valid && i2_valid) winner = (m_last_src == 1) ? 2 : 1;
      else if (i1_valid)        winner = 1;
      else if (i2_valid)        winner = 2;
    end
    chk("i1_ready", i1_ready, winner == 1);
    chk("i2_ready", i2_ready, winner == 2);
    d1 = i1; d2 = i2;
    @(posedge clk);
    if (winner == 1) begin
      m_full = 1; m_tag = 1; m_data = d1; m_last_src = 1; m_tot1++;
    end else if (winner == 2) begin
      m_full = 1; m_tag = 0; m_data = d2; m_last_src = 2; m_tot2++;
    end else if (can_take) begin
      m_full = 0;
    end
    #1;
    chk("o_valid", o_valid, m_full);
    chk("o", o, m_data);
    chk("sel", sel, m_tag);
    chk("cnt1", cnt1, m_tot1 % 256);
    chk("cnt2", cnt2, m_tot2 % 256);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1; o_ready = 1'b1;
    i1 = 8'hA5; i1_valid = 1'b1; i2 = 8'h00; i2_valid = 1'b0;
    model_reset();

    // 1: reset holds everything idle even with a word offered
    repeat (2) @(posedge clk);
    #2;
    chk("rst_o", o, 8'h00);
    chk("rst_sel", sel, 1'b0);
    chk("rst_o_valid", o_valid, 1'b0);
    chk("rst_i1_ready", i1_ready, 1'b0);
    chk("rst_cnt1", cnt1, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    i1_valid = 1'b0;

    // 2: single word from i2
    i2 = 8'h3C; i2_valid = 1'b1;
    step();
    chk("t2_o", o, 8'h3C);
    chk("t2_sel", sel, 1'b0);
    chk("t2_cnt2", cnt2, 1);
    i2_valid = 1'b0;
    step();
    chk("t2_drain", o_valid, 1'b0);

    // 3: continuous contention alternates starting with i1
    reset_dut();
    i1 = 8'h11; i2 = 8'h22; i1_valid = 1'b1; i2_valid = 1'b1; o_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t3_o", o, (k % 2 == 0) ? 8'h11 : 8'h22);
    end
    chk("t3_cnt1", cnt1, 2);
    chk("t3_cnt2", cnt2, 2);
    i2_valid = 1'b0;

    // 4: backpressure holds the slot
    i1 = 8'hB5; i1_valid = 1'b1;
    step();
    o_ready = 1'b0; i1 = 8'hC3;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t4_hold", o, 8'hB5);
    end
    o_ready = 1'b1;
    step();
    chk("t4_next", o, 8'hC3);
    i1_valid = 1'b0;
    step();

    // 5: counter wrap on i1
    reset_dut();
    i1_valid = 1'b1;
    for (int k = 0; k < 256; k++) begin
      i1 = 8'($urandom);
      step();
      if (k == 254) chk("t5_255", cnt1, 255);
    end
    chk("t5_wrap", cnt1, 0);
    chk("t5_cnt2", cnt2, 0);
    i1_valid = 1'b0;

    // 6: asynchronous reset while full, then round robin restarts at i1
    i2 = 8'h7E; i2_valid = 1'b1;
    step();
    chk("t6_full", o, 8'h7E);
    i2_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("t6_async_valid", o_valid, 1'b0);
    chk("t6_async_o", o, 8'h00);
    chk("t6_async_sel", sel, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    i1 = 8'h01; i2 = 8'h02; i1_valid = 1'b1; i2_valid = 1'b1;
    step();
    chk("t6_rr_i1", sel, 1'b1);

    // random traffic against the model
    for (int k = 0; k < 400; k++) begin
      i1 = 8'($urandom); i2 = 8'($urandom);
      i1_valid = 1'($urandom_range(0, 1));
      i2_valid = 1'($urandom_range(0, 1));
      o_ready  = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
